// File: rtl/down_counter_if.sv
// down_counter_if
// Purpose : groups the load handshake, event/abort inputs and status outputs of
//           the loadable down-counting timer into one bundle.
// Signals : load_valid_i   producer requests a load
//           load_ready_o   timer can accept a load this cycle
//           load_value_i   initial count, sampled on load_valid_i & load_ready_o
//           cnt_dec_flag_i decrement event
//           abort_i        cancel the current count
//           cnt_o          current count (registered)
//           busy_o         timer is counting
//           done_o         one-cycle pulse when the count reaches zero
// Modports: master = producer/consumer side, slave = the timer.
interface down_counter_if #(
  parameter int CNT_SIZE_WIDTH = 6
);
  logic                      load_valid_i;
  logic                      load_ready_o;
  logic [CNT_SIZE_WIDTH-1:0] load_value_i;
  logic                      cnt_dec_flag_i;
  logic                      abort_i;
  logic [CNT_SIZE_WIDTH-1:0] cnt_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    output load_valid_i, load_value_i, cnt_dec_flag_i, abort_i,
    input  load_ready_o, cnt_o, busy_o, done_o
  );

  modport slave (
    input  load_valid_i, load_value_i, cnt_dec_flag_i, abort_i,
    output load_ready_o, cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/down_counter.sv
// down_counter
// Purpose : loadable down-counting timer. A value loaded through a valid/ready
//           handshake is decremented on each cnt_dec_flag_i while running; a
//           one-cycle done pulse marks the count reaching zero. Loads above
//           CNT_MAX saturate to CNT_MAX.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous, active-high reset
//           bus  - down_counter_if.slave (load handshake, dec/abort, cnt/busy/done)
// Options : DOWN_COUNTER_AUTO_RELOAD_EN - when defined, reaching zero in RUN
//           reloads the last accepted load value and keeps running (periodic
//           mode) until abort_i; zero loads stay one-shot.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a load, count holds its last value
// RUN   | counting down, cnt >= 1, loads refused
// DONE  | count reached zero, done pulse high, loads accepted
module down_counter #(
  parameter int CNT_SIZE_WIDTH = 6,
  parameter int CNT_MAX        = 63
) (
  input logic          clk,
  input logic          rst,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_SIZE_WIDTH-1:0] CNT_MAX_L = CNT_SIZE_WIDTH'(CNT_MAX);
  localparam logic [CNT_SIZE_WIDTH-1:0] ONE       = CNT_SIZE_WIDTH'(1);
  localparam logic [CNT_SIZE_WIDTH-1:0] ZERO      = '0;

  state_t                    state_q, state_d;
  logic [CNT_SIZE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic [CNT_SIZE_WIDTH-1:0] eff;
  logic                      load_acc;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [CNT_SIZE_WIDTH-1:0] reload_q, reload_d;
`endif

  // Ready/busy are pure decodes of the state register, so no input reaches
  // an output combinationally.
  assign bus.load_ready_o = (state_q != S_RUN);
  assign bus.busy_o       = (state_q == S_RUN);
  assign bus.cnt_o        = cnt_q;
  assign bus.done_o       = done_q;

  assign load_acc = bus.load_valid_i & bus.load_ready_o;
  assign eff      = (bus.load_value_i > CNT_MAX_L) ? CNT_MAX_L : bus.load_value_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_acc) begin
          cnt_d = eff;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          reload_d = eff;
`endif
          // A zero load skips RUN entirely and completes in one cycle.
          if (eff == ZERO) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          cnt_d   = ZERO;
        end else if (bus.cnt_dec_flag_i) begin
          if (cnt_q == ONE) begin
            done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            cnt_d  = reload_q;
`else
            cnt_d   = ZERO;
            state_d = S_DONE;
`endif
          end else begin
            // cnt_q >= 2 here, so this cannot underflow.
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= ZERO;
      done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= ZERO;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter
// Purpose : directed self-checking bench for down_counter, built with
//           CNT_MAX=10 so load saturation is visible. Periodic-mode checks are
//           compiled in when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
// Ports   : none (top-level bench).
module tb_down_counter;

  localparam int W = 6;

  logic clk;
  logic rst;
  int   n_total;
  int   n_fail;

  down_counter_if #(.CNT_SIZE_WIDTH(W)) bus ();

  down_counter #(.CNT_SIZE_WIDTH(W), .CNT_MAX(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input bit busy,
                         input bit ready, input bit done);
    chk({tag, ".cnt"},   32'(bus.cnt_o),        32'(cnt));
    chk({tag, ".busy"},  32'(bus.busy_o),       32'(busy));
    chk({tag, ".ready"}, 32'(bus.load_ready_o), 32'(ready));
    chk({tag, ".done"},  32'(bus.done_o),       32'(done));
  endtask

  initial begin
    n_total = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.load_valid_i   = 1'b0;
    bus.load_value_i   = '0;
    bus.cnt_dec_flag_i = 1'b0;
    bus.abort_i        = 1'b0;

    tick();
    chk_all("reset", 0, 0, 1, 0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("idle", 0, 0, 1, 0);

    // decrement and abort are ignored in IDLE
    bus.cnt_dec_flag_i = 1'b1;
    bus.abort_i        = 1'b1;
    tick();
    tick();
    chk_all("idle_ignore", 0, 0, 1, 0);
    bus.cnt_dec_flag_i = 1'b0;
    bus.abort_i        = 1'b0;

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    // load 5, back-to-back decrements
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd5;
    tick();
    bus.load_valid_i = 1'b0;
    chk_all("l5_load", 5, 1, 0, 0);
    bus.cnt_dec_flag_i = 1'b1;
    tick(); chk_all("l5_d1", 4, 1, 0, 0);
    tick(); chk_all("l5_d2", 3, 1, 0, 0);
    tick(); chk_all("l5_d3", 2, 1, 0, 0);
    tick(); chk_all("l5_d4", 1, 1, 0, 0);
    tick(); chk_all("l5_d5", 0, 0, 1, 1);
    bus.cnt_dec_flag_i = 1'b0;
    tick(); chk_all("l5_after", 0, 0, 1, 0);

    // load 3, decrements with gaps
    begin
      bit flags[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int exp_c[6] = '{2, 2, 2, 1, 1, 0};
      bus.load_valid_i = 1'b1;
      bus.load_value_i = 6'd3;
      tick();
      bus.load_valid_i = 1'b0;
      chk_all("l3_load", 3, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
        bus.cnt_dec_flag_i = flags[i];
        tick();
        if (i == 5) chk_all("l3_gap_end", exp_c[i], 0, 1, 1);
        else        chk_all("l3_gap", exp_c[i], 1, 0, 0);
      end
      bus.cnt_dec_flag_i = 1'b0;
      tick(); chk_all("l3_after", 0, 0, 1, 0);
    end
`endif

    // load 4, two decrements, then abort together with a decrement
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd4;
    tick();
    bus.load_valid_i = 1'b0;
    chk_all("l4_load", 4, 1, 0, 0);
    bus.cnt_dec_flag_i = 1'b1;
    tick(); chk_all("l4_d1", 3, 1, 0, 0);
    tick(); chk_all("l4_d2", 2, 1, 0, 0);
    bus.abort_i = 1'b1;
    tick(); chk_all("l4_abort", 0, 0, 1, 0);
    bus.abort_i        = 1'b0;
    bus.cnt_dec_flag_i = 1'b0;
    tick(); chk_all("l4_post", 0, 0, 1, 0);

    // back-to-back zero loads, then a load accepted in DONE
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd0;
    tick(); chk_all("zero1", 0, 0, 1, 1);
    tick(); chk_all("zero2", 0, 0, 1, 1);
    bus.load_value_i = 6'd7;
    tick(); chk_all("done_load", 7, 1, 0, 0);
    bus.load_valid_i = 1'b0;
    bus.abort_i = 1'b1;
    tick(); chk_all("done_load_abort", 0, 0, 1, 0);
    bus.abort_i = 1'b0;

    // saturation, and loads refused while running
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd63;
    tick(); chk_all("sat63", 10, 1, 0, 0);
    bus.load_value_i = 6'd3;
    tick(); chk_all("run_refuse", 10, 1, 0, 0);
    bus.load_valid_i = 1'b0;
    bus.cnt_dec_flag_i = 1'b1;
    tick(); chk_all("sat_dec", 9, 1, 0, 0);
    bus.cnt_dec_flag_i = 1'b0;

    // reset in the middle of a count
    rst = 1'b1;
    tick(); chk_all("mid_rst", 0, 0, 1, 0);
    rst = 1'b0;
    tick();

    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd11;
    tick(); chk_all("sat11", 10, 1, 0, 0);
    bus.load_valid_i = 1'b0;
    bus.abort_i = 1'b1;
    tick(); chk_all("sat11_abort", 0, 0, 1, 0);
    bus.abort_i = 1'b0;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // periodic mode: load 2, continuous decrements
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd2;
    tick();
    bus.load_valid_i = 1'b0;
    chk_all("ar_load", 2, 1, 0, 0);
    bus.cnt_dec_flag_i = 1'b1;
    tick(); chk_all("ar_d1", 1, 1, 0, 0);
    tick(); chk_all("ar_d2", 2, 1, 0, 1);
    tick(); chk_all("ar_d3", 1, 1, 0, 0);
    tick(); chk_all("ar_d4", 2, 1, 0, 1);
    tick(); chk_all("ar_d5", 1, 1, 0, 0);
    rst = 1'b1;
    tick(); chk_all("ar_rst", 0, 0, 1, 0);
    rst = 1'b0;
    bus.cnt_dec_flag_i = 1'b0;
    tick();
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd3;
    tick(); chk_all("ar_load3", 3, 1, 0, 0);
    bus.load_valid_i = 1'b0;
    bus.cnt_dec_flag_i = 1'b1;
    tick(); chk_all("ar3_d1", 2, 1, 0, 0);
    tick(); chk_all("ar3_d2", 1, 1, 0, 0);
    tick(); chk_all("ar3_d3", 3, 1, 0, 1);
    bus.abort_i = 1'b1;
    tick(); chk_all("ar_abort", 0, 0, 1, 0);
    bus.abort_i = 1'b0;
    bus.cnt_dec_flag_i = 1'b0;
    bus.load_valid_i = 1'b1;
    bus.load_value_i = 6'd0;
    tick(); chk_all("ar_zero", 0, 0, 1, 1);
    bus.load_valid_i = 1'b0;
    tick(); chk_all("ar_zero_after", 0, 0, 1, 0);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
